// File: rtl/hex_line_rx.sv
// Parses ASCII hex lines ("0x" prefix optional, 1..MAX_DIGITS digits, CR/LF) from a UART byte stream.
// Emits one strobe per well-formed line and one error pulse per malformed line.
module hex_line_rx #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  output logic        o_stb,
  output logic [31:0] o_data,
  output logic [3:0]  o_ndigits,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NIB_W  = 4;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_DIGITS);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    PREFIX,
    DIGITS,
    DISCARD
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               stb_d, err_d;
  logic [DATA_W-1:0]  data_d;
  logic [CNT_W-1:0]   ndigits_d;

  // Byte classification and ASCII-to-nibble conversion
  logic [7:0]       lower_c;
  logic             is_dec_c, is_alpha_c, is_hex_c, is_term_c, is_x_c, is_zero_c;
  logic [NIB_W-1:0] nibble_c;
  logic [DATA_W-1:0] shifted_c;
  logic [CNT_W-1:0]  n_inc_c;

  always_comb begin
    lower_c    = i_byte | 8'h20;
    is_dec_c   = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    is_alpha_c = (lower_c >= 8'h61) && (lower_c <= 8'h66);
    is_hex_c   = is_dec_c || is_alpha_c;
    is_term_c  = (i_byte == 8'h0D) || (i_byte == 8'h0A);
    is_x_c     = (lower_c == 8'h78);
    is_zero_c  = (i_byte == 8'h30);
    // Letters: (byte|0x20)-0x57 has the same low nibble as lower[3:0]+9
    nibble_c   = is_dec_c ? i_byte[NIB_W-1:0] : NIB_W'(lower_c[NIB_W-1:0] + 4'd9);
    shifted_c  = {acc_q[DATA_W-NIB_W-1:0], nibble_c};
    n_inc_c    = n_q + CNT_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    n_d       = n_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    data_d    = o_data;
    ndigits_d = o_ndigits;

    if (i_stb) begin
      unique case (state_q)
        IDLE: begin
          if (is_zero_c) begin
            state_d = ZERO;
            acc_d   = '0;
            n_d     = CNT_W'(1);
          end else if (is_hex_c) begin
            state_d = DIGITS;
            acc_d   = DATA_W'(nibble_c);
            n_d     = CNT_W'(1);
          end else if (!is_term_c) begin
            state_d = DISCARD;
          end
        end
        ZERO: begin
          if (is_x_c) begin
            state_d = PREFIX;
            acc_d   = '0;
            n_d     = '0;
          end else if (is_hex_c) begin
            state_d = (n_q >= MAX_N) ? DISCARD : DIGITS;
            acc_d   = shifted_c;
            n_d     = n_inc_c;
          end else if (is_term_c) begin
            state_d   = IDLE;
            stb_d     = 1'b1;
            data_d    = acc_q;
            ndigits_d = n_q;
          end else begin
            state_d = DISCARD;
          end
        end
        PREFIX: begin
          if (is_hex_c) begin
            state_d = DIGITS;
            acc_d   = shifted_c;
            n_d     = n_inc_c;
          end else if (is_term_c) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = DISCARD;
          end
        end
        DIGITS: begin
          if (is_hex_c) begin
            if (n_q >= MAX_N) begin
              state_d = DISCARD;
            end else begin
              acc_d = shifted_c;
              n_d   = n_inc_c;
            end
          end else if (is_term_c) begin
            state_d   = IDLE;
            stb_d     = 1'b1;
            data_d    = acc_q;
            ndigits_d = n_q;
          end else begin
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term_c) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      n_q       <= '0;
      o_stb     <= 1'b0;
      o_err     <= 1'b0;
      o_data    <= '0;
      o_ndigits <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      n_q       <= n_d;
      o_stb     <= stb_d;
      o_err     <= err_d;
      o_data    <= data_d;
      o_ndigits <= ndigits_d;
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
